// File: rtl/memory_access_unit.sv
// SRAM access sequencer: accepts one read/write request, holds the SRAM strobes for a fixed
// number of wait cycles, then pulses rsp_valid (the MDR load enable) for one cycle.
module memory_access_unit #(
  parameter int unsigned width       = 16,
  parameter int unsigned addr_width  = 16,
  parameter int unsigned wait_cycles = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [addr_width-1:0] req_addr,
  input  logic [width-1:0]      req_wdata,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [width-1:0]      rsp_rdata,
  output logic                  mem_ce_n,
  output logic                  mem_oe_n,
  output logic                  mem_we_n,
  output logic [addr_width-1:0] mem_addr,
  output logic [width-1:0]      mem_wdata,
  input  logic [width-1:0]      mem_rdata
);

  if (wait_cycles < 1 || wait_cycles > 15) begin : g_bad_wait_cycles
    $error("memory_access_unit: wait_cycles must be in 1..15");
  end

  localparam logic [3:0] CntInit = 4'(wait_cycles - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic [width-1:0]      wdata_q, wdata_d;
  logic [width-1:0]      rdata_q, rdata_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d = StAccess;
          cnt_d   = CntInit;
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
        end
      end
      StAccess: begin
        if (cnt_q == 4'd0) begin
          state_d = StDone;
          // Read data is sampled on the final edge of the access window.
          if (!we_q) rdata_d = mem_rdata;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Strobes decode straight from the state register so reset releases them asynchronously.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_ce_n  = 1'b1;
    mem_oe_n  = 1'b1;
    mem_we_n  = 1'b1;
    case (state_q)
      StIdle:   req_ready = 1'b1;
      StAccess: begin
        mem_ce_n = 1'b0;
        mem_oe_n = we_q;
        mem_we_n = ~we_q;
      end
      StDone:   rsp_valid = 1'b1;
      default:  req_ready = 1'b0;
    endcase
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rsp_rdata = rdata_q;

endmodule
